// File: rtl/sodor_mem_arb_pkg.sv
// Shared types for the Sodor imem/dmem memory-port arbiter.
package sodor_mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_write;
  } arb_tag_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    logic                  write_en;
  } mem_req_t;

endpackage

// File: rtl/sodor_arb_tag_fifo.sv
// Tag FIFO recording owner and write flag of every outstanding memory access.
module sodor_arb_tag_fifo
  import sodor_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  arb_tag_t                 push_tag,
  input  logic                     pop,
  output arb_tag_t                 pop_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  arb_tag_t         store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_tag = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_tag;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between Sodor imem and dmem,
// routing in-order memory responses back to the requester that issued them.
module sodor_mem_arbiter
  import sodor_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_data,
  input  logic              d_req_write_en,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_write_en,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err_unexpected_resp
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

  logic              slot_valid;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;
  logic              slot_write_en;
  owner_e            last_grant;

  logic              can_issue;
  logic              grant_i;
  logic              grant_d;
  logic              grant;
  logic              resp_pop;
  arb_tag_t          push_tag;
  arb_tag_t          head_tag;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_full;
  logic              tag_empty;

  // Outstanding count advances at grant time, so a request still parked in
  // the slot already consumes one of the MAX_OUT credits.
  always_comb begin
    can_issue = (!slot_valid || mem_req_ready) && (tag_count < CNT_W'(MAX_OUT));
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (can_issue) begin
      if (i_req_valid && d_req_valid) begin
        grant_i = (last_grant == OWNER_D);
        grant_d = (last_grant == OWNER_I);
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  assign grant             = grant_i || grant_d;
  assign i_req_ready       = grant_i;
  assign d_req_ready       = grant_d;
  assign push_tag.owner    = grant_d ? OWNER_D : OWNER_I;
  assign push_tag.is_write = grant_d && d_req_write_en;
  assign resp_pop          = mem_resp_valid && !tag_empty;

  assign mem_req_valid     = slot_valid;
  assign mem_req_addr      = slot_addr;
  assign mem_req_data      = slot_data;
  assign mem_req_write_en  = slot_write_en;

  sodor_arb_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (grant),
    .push_tag (push_tag),
    .pop      (resp_pop),
    .pop_tag  (head_tag),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid    <= 1'b0;
      slot_addr     <= '0;
      slot_data     <= '0;
      slot_write_en <= 1'b0;
      last_grant    <= OWNER_D;
    end else if (grant) begin
      slot_valid    <= 1'b1;
      slot_addr     <= grant_d ? d_req_addr : i_req_addr;
      slot_data     <= grant_d ? d_req_data : '0;
      slot_write_en <= grant_d && d_req_write_en;
      last_grant    <= push_tag.owner;
    end else if (mem_req_ready) begin
      slot_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_resp_valid        <= 1'b0;
      i_resp_data         <= '0;
      d_resp_valid        <= 1'b0;
      d_resp_data         <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (mem_resp_valid) begin
        if (tag_empty) begin
          err_unexpected_resp <= 1'b1;
        end else if (head_tag.owner == OWNER_I) begin
          i_resp_valid <= 1'b1;
          i_resp_data  <= mem_resp_data;
        end else begin
          d_resp_valid <= 1'b1;
          d_resp_data  <= head_tag.is_write ? '0 : mem_resp_data;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(grant && tag_full));

endmodule

// File: doc/sodor_mem_arbiter.md
# sodor_mem_arbiter

Round-robin arbiter that shares a single backing memory port between the Sodor core's instruction-fetch and data requesters. It sits between the core's imem/dmem interfaces and the memory model, which is accessed through a valid/ready request channel and an in-order response channel. The block registers the granted request and tracks the owner of every outstanding access in a small tag FIFO. It then routes each returned response back to the requester that issued it.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_OUT`, 4, max outstanding memory requests (power of 2, ≥2)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `i_req_valid` / `i_req_ready`  in/out  1  instruction request handshake
- `i_req_addr`  in  ADDR_W  fetch address (read-only requester)
- `i_resp_valid`  out  1  fetch response strobe
- `i_resp_data`  out  DATA_W  fetched instruction
- `d_req_valid` / `d_req_ready`  in/out  1  data request handshake
- `d_req_addr`  in  ADDR_W  data address
- `d_req_data`  in  DATA_W  write data
- `d_req_write_en`  in  1  1 = write, 0 = read
- `d_resp_valid`  out  1  data response strobe (reads and writes)
- `d_resp_data`  out  DATA_W  read data; 0 for writes
- `mem_req_valid` / `mem_req_ready`  out/in  1  memory request handshake
- `mem_req_addr`, `mem_req_data`, `mem_req_write_en`  out  ADDR_W/DATA_W/1  registered request
- `mem_resp_valid`  in  1  memory response strobe; exactly one per accepted request, in order
- `mem_resp_data`  in  DATA_W  response data
- `err_unexpected_resp`  out  1  sticky: response arrived with no request outstanding

## Operation
- Output stage: one register slot holding {addr, data, write_en, owner}. `mem_req_valid` = slot full. The slot stays stable while `mem_req_valid && !mem_req_ready`.
- `can_issue` = (slot empty OR `mem_req_ready`) AND (outstanding count < MAX_OUT).
- Outstanding count is incremented on a requester grant, not on memory acceptance. Issued-but-unaccepted requests therefore count toward MAX_OUT.
- Arbitration is combinational among the valid requesters when `can_issue`:
  - If only one is valid, it is granted.
  - If both are valid, grant the requester not granted last (`last_grant` register).
  - `x_req_ready` = `can_issue` AND (x is the granted requester).
  - Ready never asserts for a non-valid requester.
- On grant, load the slot and push the owner (0 = I, 1 = D) into the tag FIFO. Update `last_grant`.
- On `mem_resp_valid`, pop the tag FIFO and register the response to the owner's resp port:
  - `resp_data` = `mem_resp_data` for reads, 0 for data writes.
  - The write flag is stored in the tag alongside the owner.
- Requester responses have no backpressure. Requesters must accept on the strobe.
- If `mem_resp_valid` arrives while the FIFO is empty:
  - Set `err_unexpected_resp` (sticky until reset).
  - Drive no requester response.
  - Leave the count unchanged.
- Simultaneous grant and response in one cycle: push and pop both occur and the count is unchanged. When the count equals MAX_OUT, no grant is made, even if a pop occurs the same cycle.
- Reset values: slot empty, `mem_req_valid` = 0, count = 0, FIFO pointers = 0, `last_grant` = D (so I wins the first tie), `i_resp_valid` = `d_resp_valid` = 0, resp data = 0, `err_unexpected_resp` = 0.
- Reset mid-operation drops all outstanding tags. Responses arriving after reset raise the error flag.

## Timing
- Grant in cycle N → `mem_req_valid` with the request in N+1.
- Memory response in cycle M → owner `resp_valid` in M+1, a one-cycle pulse.
- Sustained throughput: one grant per cycle while `mem_req_ready` = 1 and count < MAX_OUT.
- Minimum round trip from requester grant to response strobe: 2 cycles plus memory latency.
- Backpressure: while `mem_req_ready` = 0 with the slot full, both requester readys are 0.

## Structure
- Package `sodor_mem_arb_pkg`:
  - `owner_e` enum {OWNER_I, OWNER_D}
  - `arb_tag_t` struct {owner, is_write}
  - `mem_req_t` struct {addr, data, write_en}
- Sub-module `sodor_arb_tag_fifo`:
  - Synchronous FIFO of `arb_tag_t`, depth MAX_OUT, with pointer wrap.
  - Outputs: count, full, empty.
  - Supports simultaneous push and pop.

## Test plan
- **Single fetch:** `i_req_valid` with addr 0x100, `mem_req_ready` = 1, memory replies 0x00000013 two cycles later. Expect `mem_req_addr` = 0x100 one cycle after the grant, then `i_resp_valid` with 0x00000013 one cycle after the reply; `d_resp_valid` stays 0.
- **Fairness:** hold both I and D valid for 6 cycles with memory always ready. Expect grants to alternate I, D, I, D, I, D starting with I after reset.
- **Write response:** a data write to 0x2000 with data 0xDEADBEEF, memory returns 0xFFFFFFFF. Expect `mem_req_write_en` = 1 and `d_resp_valid` with `d_resp_data` = 0.
- **Outstanding limit:** hold `mem_resp_valid` low and issue 5 fetches with MAX_OUT = 4. Expect the 5th `i_req_ready` to stay 0 until the first response. Then return responses A, B, C, D and confirm they are routed in order.
- **Backpressure:** `mem_req_ready` = 0 for 3 cycles with the slot full. Expect addr, data and write_en stable, both readys 0, and transfer on the 4th cycle.
- **Error and reset:** `mem_resp_valid` with no request outstanding sets `err_unexpected_resp` = 1 and produces no requester strobe. Asserting `reset` for 1 cycle clears the flag and all outputs return to their reset values.
